// File: rtl/data_ram_responder.sv
// data_ram_responder
// Single-port 256 x 32 data memory behind a simple req/ack handshake.
// After reset the whole array is zeroed (CLEAR, 256 cycles). Then one access
// is accepted at a time in IDLE, held for WAIT_CYCLES cycles, and completed
// on the edge that enters RESP, where ack (and err for size=11) pulses.
//
// Ports
//   clk     : clock, all state changes on the rising edge
//   rst     : synchronous active-high reset
//   req     : access strobe, only looked at while ready=1
//   ram_en  : 1 = write, 0 = read
//   addr    : word index 0..255
//   ram_in  : write data, low-lane aligned
//   size    : 00 byte, 01 half, 10 word, 11 illegal
//   ram_out : registered read data, held until the next legal read completes
//   ready   : high in IDLE only
//   ack     : one-cycle completion pulse
//   err     : pulses with ack when the access used size=11
module data_ram_responder #(
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        ram_en,
   input  logic [7:0]  addr,
   input  logic [31:0] ram_in,
   input  logic [1:0]  size,
   output logic [31:0] ram_out,
   output logic        ready,
   output logic        ack,
   output logic        err
);

   typedef enum logic [1:0] {
      S_CLEAR = 2'd0,
      S_IDLE  = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   state_t      state_reg, state_next;
   logic [7:0]  clr_ptr_reg, clr_ptr_next;
   logic [3:0]  cnt_reg, cnt_next;

   // Latched copy of the accepted request
   logic        en_reg;
   logic [7:0]  addr_reg;
   logic [31:0] data_reg;
   logic [1:0]  size_reg;

   logic        latch_en;
   logic        access_go;

   // Operands of the access that completes this edge
   logic        op_en;
   logic [7:0]  op_addr;
   logic [31:0] op_data;
   logic [1:0]  op_size;

   logic [3:0]  mem_we;
   logic [7:0]  mem_waddr;
   logic [31:0] mem_wdata;
   logic        rd_go;
   logic [31:0] rd_word;
   logic [31:0] ram_out_reg;

   // State and request latch
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= S_CLEAR;
         clr_ptr_reg <= 8'd0;
         cnt_reg     <= 4'd0;
         en_reg      <= 1'b0;
         addr_reg    <= 8'd0;
         data_reg    <= 32'd0;
         size_reg    <= 2'd0;
      end else begin
         state_reg   <= state_next;
         clr_ptr_reg <= clr_ptr_next;
         cnt_reg     <= cnt_next;
         if (latch_en) begin
            en_reg   <= ram_en;
            addr_reg <= addr;
            data_reg <= ram_in;
            size_reg <= size;
         end
      end
   end

   // Next state and handshake outputs
   always_comb begin
      state_next   = state_reg;
      clr_ptr_next = clr_ptr_reg;
      cnt_next     = cnt_reg;
      latch_en     = 1'b0;
      access_go    = 1'b0;
      ready        = 1'b0;
      ack          = 1'b0;
      err          = 1'b0;
      case (state_reg)
         S_CLEAR: begin
            clr_ptr_next = clr_ptr_reg + 8'd1;
            if (clr_ptr_reg == 8'hFF) begin
               state_next = S_IDLE;
            end
         end
         S_IDLE: begin
            ready = 1'b1;
            if (req) begin
               latch_en = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  // No wait: complete straight from the live inputs
                  state_next = S_RESP;
                  access_go  = 1'b1;
               end else begin
                  state_next = S_WAIT;
                  cnt_next   = WAIT_INIT;
               end
            end
         end
         S_WAIT: begin
            cnt_next = cnt_reg - 4'd1;
            if (cnt_reg <= 4'd1) begin
               state_next = S_RESP;
               access_go  = 1'b1;
            end
         end
         S_RESP: begin
            ack        = 1'b1;
            err        = (size_reg == 2'b11);
            state_next = S_IDLE;
         end
         default: state_next = S_CLEAR;
      endcase
   end

   // In IDLE the access can only complete when WAIT_CYCLES=0, and then the
   // latch is being loaded on the same edge, so use the inputs directly.
   always_comb begin
      if (state_reg == S_IDLE) begin
         op_en   = ram_en;
         op_addr = addr;
         op_data = ram_in;
         op_size = size;
      end else begin
         op_en   = en_reg;
         op_addr = addr_reg;
         op_data = data_reg;
         op_size = size_reg;
      end
   end

   // Memory port control; reset suppresses every write and read
   always_comb begin
      mem_we    = 4'b0000;
      mem_waddr = op_addr;
      mem_wdata = op_data;
      rd_go     = 1'b0;
      if (!rst) begin
         if (state_reg == S_CLEAR) begin
            mem_we    = 4'b1111;
            mem_waddr = clr_ptr_reg;
            mem_wdata = 32'd0;
         end else if (access_go && op_size != 2'b11) begin
            if (op_en) begin
               case (op_size)
                  2'b00:   mem_we = 4'b0001;
                  2'b01:   mem_we = 4'b0011;
                  default: mem_we = 4'b1111;
               endcase
            end else begin
               rd_go = 1'b1;
            end
         end
      end
   end

   // One 256 x 8 array per byte lane so partial writes need no read-modify-write
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [256];

      always_ff @(posedge clk) begin
         if (mem_we[gi]) begin
            lane_mem[mem_waddr] <= mem_wdata[gi*8 +: 8];
         end
      end

      assign rd_word[gi*8 +: 8] = lane_mem[op_addr];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ram_out_reg <= 32'd0;
      end else if (rd_go) begin
         ram_out_reg <= rd_word;
      end
   end

   assign ram_out = ram_out_reg;

endmodule
